trace_step_tx: RTL and testbench

Serializes one 560-bit trace step into a framed byte stream: sync byte, 70 payload bytes, XOR checksum byte. It sits on the producer side of the step interface that the tiny86 core consumes. The tracer and host model hand it complete steps, and it streams them off-chip or into a trace FIFO over a valid/ready byte link. The step is opaque here; field layout is owned by the consumer's fetch stage.

---
 rtl/trace_step_tx.sv | 91 +++++++++
 tb/tb_trace_step_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_step_tx.sv
// Frames one 560-bit trace step as a byte stream: sync byte, 70 payload bytes
// (byte 0 first), then an XOR checksum of the payload on the out_last beat.
module trace_step_tx #(
   parameter logic [7:0] SYNC_BYTE  = 8'hA5,
   parameter int         STEP_BYTES = 70
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [STEP_BYTES*8-1:0]   in_step,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [7:0]                out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic [31:0]               frames_sent
);

   typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CSUM} state_t;

   localparam logic [6:0] LAST_IDX = 7'(STEP_BYTES - 1);

   state_t                  state;
   logic [STEP_BYTES*8-1:0] hold;
   logic [6:0]              idx;
   logic [7:0]              csum;
   logic                    accept;

   // in_ready depends combinationally on out_ready so a new step can be taken
   // on the same edge as the checksum beat, giving back-to-back frames.
   assign in_ready = (state == IDLE) | ((state == CSUM) & out_ready);
   assign accept   = in_valid & in_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         hold        <= '0;
         idx         <= '0;
         csum        <= '0;
         frames_sent <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_last    <= 1'b0;
      end else begin
         if ((state == CSUM) && out_ready)
            frames_sent <= frames_sent + 32'd1;

         if (accept) begin
            hold      <= in_step;
            csum      <= '0;
            idx       <= '0;
            state     <= SYNC;
            out_valid <= 1'b1;
            out_data  <= SYNC_BYTE;
            out_last  <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               // The holding register shifts down one byte per payload beat,
               // so hold[7:0] is always the next byte to present.
               SYNC: if (out_ready) begin
                  state    <= PAYLOAD;
                  out_data <= hold[7:0];
                  hold     <= hold >> 8;
               end
               PAYLOAD: if (out_ready) begin
                  csum <= csum ^ out_data;
                  if (idx == LAST_IDX) begin
                     state    <= CSUM;
                     out_data <= csum ^ out_data;
                     out_last <= 1'b1;
                  end else begin
                     idx      <= idx + 7'd1;
                     out_data <= hold[7:0];
                     hold     <= hold >> 8;
                  end
               end
               CSUM: if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_data  <= '0;
                  out_last  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trace_step_tx.sv
// Directed bench for trace_step_tx: stimulus pushes expected beats into a
// queue, an independent monitor pops and compares on every completed beat.
module tb_trace_step_tx;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [559:0] in_step = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         out_last;
   logic         busy;
   logic [31:0]  frames_sent;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Entry: {first, last, data}
   logic [9:0] exp_q[$];
   logic [9:0] e;
   int         fstart[$];
   int         fend[$];
   logic [7:0] fcsum[$];

   trace_step_tx dut (
      .clk(clk), .rst(rst), .in_step(in_step), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy),
      .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: samples just after the falling edge, i.e. the beat that the
   // next rising edge will complete.
   always @(negedge clk) begin
      #1;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", out_data);
         end else begin
            e = exp_q.pop_front();
            check("beat", 32'({out_last, out_data}), 32'(e[8:0]));
            if (e[9]) fstart.push_back(cyc);
            if (e[8]) begin
               fend.push_back(cyc);
               fcsum.push_back(out_data);
            end
         end
      end
   end

   task automatic push_frame(input logic [559:0] step);
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'h00;
      exp_q.push_back({2'b10, 8'hA5});
      for (int k = 0; k < 70; k++) begin
         b = step[8*k +: 8];
         cs = cs ^ b;
         exp_q.push_back({2'b00, b});
      end
      exp_q.push_back({2'b01, cs});
   endtask

   task automatic send(input logic [559:0] step, input bit keep);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_step  = step;
      in_valid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         #1;
         if (in_ready) begin
            push_frame(step);
            ok = 1'b1;
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
      if (!keep) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         #2;
         if (exp_q.size() == 0 && !busy) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout actual=pending%0d required=0", exp_q.size());
      end
   endtask

   task automatic clear_log();
      fstart.delete();
      fend.delete();
      fcsum.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [559:0] step;
      bit seen;

      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_frames", frames_sent, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // All-zero step
      send('0, 1'b0);
      wait_done();
      check("zero_len", 32'(fend[0] - fstart[0] + 1), 32'd72);
      check("zero_csum", 32'(fcsum[0]), 32'h00);
      check("zero_frames", frames_sent, 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      clear_log();

      // Sparse step: checksum 01^02^80
      step = '0;
      step[7:0]     = 8'h01;
      step[15:8]    = 8'h02;
      step[559:552] = 8'h80;
      send(step, 1'b0);
      wait_done();
      check("sparse_csum", 32'(fcsum[0]), 32'h83);
      check("sparse_frames", frames_sent, 32'd2);
      clear_log();

      // Backpressure for 5 cycles while payload byte 10 is presented
      for (int k = 0; k < 70; k++) step[8*k +: 8] = 8'(k * 7 + 3);
      send(step, 1'b0);
      repeat (11) @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_hold_data", 32'(out_data), 32'(step[87:80]));
         check("bp_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_done();
      check("bp_len", 32'(fend[0] - fstart[0] + 1), 32'd77);
      check("bp_frames", frames_sent, 32'd3);
      clear_log();

      // Back-to-back frames with in_valid held high
      send({70{8'hFF}}, 1'b1);
      send({70{8'h11}}, 1'b0);
      wait_done();
      check("b2b_gap", 32'(fstart[1] - fend[0]), 32'd1);
      check("b2b_span", 32'(fend[1] - fstart[0] + 1), 32'd144);
      check("b2b_csum0", 32'(fcsum[0]), 32'h00);
      check("b2b_csum1", 32'(fcsum[1]), 32'h00);
      check("b2b_frames", frames_sent, 32'd5);
      clear_log();

      // Reset pulse mid-payload (byte 35 on the bus)
      send({70{8'h33}}, 1'b0);
      repeat (36) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_frames", frames_sent, 32'd0);
      exp_q.delete();
      clear_log();
      @(negedge clk);
      #2;
      rst = 1'b0;
      send({70{8'h5A}}, 1'b0);
      wait_done();
      check("post_rst_len", 32'(fend[0] - fstart[0] + 1), 32'd72);
      check("post_rst_csum", 32'(fcsum[0]), 32'h00);
      check("post_rst_frames", frames_sent, 32'd1);
      clear_log();

      // Counter wrap
      send(step, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (out_last) seen = 1'b1;
      end
      check("wrap_reach_csum", 32'(seen), 32'd1);
      force dut.frames_sent = 32'hFFFF_FFFF;
      #1;
      release dut.frames_sent;
      @(negedge clk);
      #2;
      check("wrap_frames", frames_sent, 32'h0000_0000);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
